// File: rtl/seq_detector_param.sv
// -----------------------------------------------------------------------------
// seq_detector_param
//
// Parametrised Moore serial sequence detector. Bits on din are shifted into a
// history register on cycles where en=1; when the most recent N samples equal
// the pattern register, the FSM enters HIT for one cycle and the saturating
// match counter is bumped. The pattern can be replaced at run time with load.
//
// Parameters:
//   N        pattern length in bits (N >= 2)
//   PATTERN  pattern used after reset, MSB is the first bit received
//   OVERLAP  1: history kept across a match, 0: history discarded on a match
//   CNT_W    width of the match counter
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   en         sample enable for din
//   din        serial data bit
//   load       load pat_in into the pattern register (wins over en)
//   pat_in     new pattern, MSB first
//   clr_cnt    synchronous clear of match_cnt
//   dout       registered match pulse, high only in HIT
//   match_cnt  saturating number of matches
// -----------------------------------------------------------------------------
module seq_detector_param #(
  parameter int unsigned    N       = 4,
  parameter logic [N-1:0]   PATTERN = N'(4'b1001),
  parameter bit             OVERLAP = 1'b1,
  parameter int unsigned    CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  input  logic             load,
  input  logic [N-1:0]     pat_in,
  input  logic             clr_cnt,
  output logic             dout,
  output logic [CNT_W-1:0] match_cnt
);

  // Fill counter must hold the value N itself.
  localparam int unsigned FW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HIT  = 2'b10
  } state_e;

  state_e             state_q, state_d;
  logic [N-1:0]       hist_q,  hist_d;
  logic [FW-1:0]      fill_q,  fill_d;
  logic [N-1:0]       pat_q,   pat_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic               dout_q,  dout_d;

  logic               sampling;
  logic               match_ev;
  logic [N-1:0]       shifted;
  logic [FW-1:0]      fill_inc;

  // A sample is only taken once the FSM has left IDLE; a load on the same
  // cycle swallows the bit.
  assign sampling = ((state_q == RUN) || (state_q == HIT)) && en && !load;
  assign shifted  = {hist_q[N-2:0], din};
  assign fill_inc = (fill_q == FW'(N)) ? fill_q : fill_q + FW'(1);
  // The fill qualifier keeps the all-zero reset history from matching a
  // pattern such as 0001 before N real bits have been seen.
  assign match_ev = sampling && (shifted == pat_q) && (fill_q >= FW'(N - 1));

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // leaves a value unassigned and no latch is inferred.
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    pat_d   = pat_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: state_d = RUN;
      RUN, HIT: begin
        state_d = RUN;
        if (sampling) begin
          hist_d = shifted;
          fill_d = fill_inc;
          if (match_ev) begin
            state_d = HIT;
            if (!OVERLAP) fill_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      pat_d   = pat_in;
      fill_d  = '0;
      state_d = RUN;
    end

    // A clear coinciding with a match leaves exactly that one match counted.
    if (match_ev) begin
      if (clr_cnt)           cnt_d = CNT_W'(1);
      else if (cnt_q != '1)  cnt_d = cnt_q + CNT_W'(1);
    end else if (clr_cnt) begin
      cnt_d = '0;
    end

    // Output is registered alongside the state so dout mirrors HIT exactly.
    dout_d = (state_d == HIT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      hist_q  <= '0;
      fill_q  <= '0;
      pat_q   <= PATTERN;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the
      // values present before the edge, independent of statement order.
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
    end
  end

  assign dout      = dout_q;
  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// -----------------------------------------------------------------------------
// tb_seq_detector_param
//
// Three detectors share one stimulus stream: overlapping with an 8-bit
// counter, non-overlapping with an 8-bit counter, and overlapping with a
// 2-bit counter. Expected values are hand-derived for each directed step.
// -----------------------------------------------------------------------------
module tb_seq_detector_param;

  logic       clk;
  logic       rst;
  logic       en;
  logic       din;
  logic       load;
  logic [3:0] pat_in;
  logic       clr_cnt;

  logic       dout_ov, dout_nov, dout_c2;
  logic [7:0] cnt_ov, cnt_nov;
  logic [1:0] cnt_c2;

  int n_checks = 0;
  int n_errors = 0;

  seq_detector_param #(.N(4), .PATTERN(4'b1001), .OVERLAP(1'b1), .CNT_W(8)) u_ov (
    .clk(clk), .rst(rst), .en(en), .din(din), .load(load), .pat_in(pat_in),
    .clr_cnt(clr_cnt), .dout(dout_ov), .match_cnt(cnt_ov)
  );

  seq_detector_param #(.N(4), .PATTERN(4'b1001), .OVERLAP(1'b0), .CNT_W(8)) u_nov (
    .clk(clk), .rst(rst), .en(en), .din(din), .load(load), .pat_in(pat_in),
    .clr_cnt(clr_cnt), .dout(dout_nov), .match_cnt(cnt_nov)
  );

  seq_detector_param #(.N(4), .PATTERN(4'b1001), .OVERLAP(1'b1), .CNT_W(2)) u_c2 (
    .clk(clk), .rst(rst), .en(en), .din(din), .load(load), .pat_in(pat_in),
    .clr_cnt(clr_cnt), .dout(dout_c2), .match_cnt(cnt_c2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply one set of inputs across a rising edge; outputs are sampled 1 ns later.
  task automatic cycle(input logic e, input logic d);
    en  = e;
    din = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; din = 1'b0; load = 1'b0; pat_in = 4'b0000; clr_cnt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset dout_ov", dout_ov, 0);
    check("reset dout_nov", dout_nov, 0);
    check("reset cnt_ov", cnt_ov, 0);
    check("reset cnt_c2", cnt_c2, 0);

    // Release reset; the IDLE-cycle bit is ignored.
    rst = 1'b1;
    cycle(1, 1);
    check("idle dout", dout_ov, 0);

    // Stream 1,0,0,1,0,0,1
    cycle(1, 1); cycle(1, 0); cycle(1, 0);
    check("pre-match dout", dout_ov, 0);
    cycle(1, 1);
    check("m1 dout_ov", dout_ov, 1);
    check("m1 dout_nov", dout_nov, 1);
    check("m1 cnt_ov", cnt_ov, 1);
    check("m1 cnt_nov", cnt_nov, 1);
    cycle(1, 0);
    check("m1 pulse width", dout_ov, 0);
    cycle(1, 0);
    cycle(1, 1);
    check("m2 dout_ov overlap", dout_ov, 1);
    check("m2 dout_nov no overlap", dout_nov, 0);
    check("m2 cnt_ov", cnt_ov, 2);
    check("m2 cnt_nov", cnt_nov, 1);
    check("m2 cnt_c2", cnt_c2, 2);

    // Partial 1,0, three en=0 cycles, then 0,1
    cycle(1, 1); cycle(1, 0);
    check("gap pre dout", dout_ov, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1);
      check("gap dout_ov", dout_ov, 0);
      check("gap dout_nov", dout_nov, 0);
    end
    cycle(1, 0);
    check("gap 3rd dout", dout_ov, 0);
    cycle(1, 1);
    check("gap match dout_ov", dout_ov, 1);
    check("gap match dout_nov", dout_nov, 1);
    check("gap match cnt_ov", cnt_ov, 3);
    check("gap match cnt_nov", cnt_nov, 2);
    check("gap match cnt_c2", cnt_c2, 3);
    cycle(0, 1);
    check("en0 in HIT drops dout", dout_ov, 0);
    check("en0 holds cnt", cnt_ov, 3);

    // History ends in 000, then load 0001: a lone 1 must be rejected by fill.
    cycle(1, 0); cycle(1, 0); cycle(1, 0);
    load = 1'b1; pat_in = 4'b0001;
    cycle(1, 1);
    load = 1'b0;
    check("load dout", dout_ov, 0);
    check("load keeps cnt", cnt_ov, 3);
    cycle(1, 1);
    check("fill guard dout_ov", dout_ov, 0);
    check("fill guard dout_nov", dout_nov, 0);
    cycle(1, 0); cycle(1, 0); cycle(1, 0);
    check("0001 pre dout", dout_ov, 0);
    cycle(1, 1);
    check("0001 match dout_ov", dout_ov, 1);
    check("0001 match dout_nov", dout_nov, 1);
    check("0001 cnt_ov", cnt_ov, 4);
    check("0001 cnt_nov", cnt_nov, 3);
    check("cnt_c2 saturates", cnt_c2, 3);

    // Mid-stream reload after 1,0,0 with pattern 1110.
    cycle(1, 1); cycle(1, 0); cycle(1, 0);
    load = 1'b1; pat_in = 4'b1110;
    cycle(1, 1);
    load = 1'b0;
    check("reload dout", dout_ov, 0);
    cycle(1, 1);
    check("reload single 1 dout", dout_ov, 0);
    cycle(1, 1); cycle(1, 1);
    check("1110 pre dout", dout_ov, 0);
    cycle(1, 0);
    check("1110 match dout_ov", dout_ov, 1);
    check("1110 match dout_nov", dout_nov, 1);
    check("1110 cnt_ov", cnt_ov, 5);
    check("1110 cnt_nov", cnt_nov, 4);
    check("1110 cnt_c2 held", cnt_c2, 3);

    // clr_cnt coincident with a match leaves a count of one.
    cycle(1, 1);
    check("after 1110 dout", dout_ov, 0);
    cycle(1, 1); cycle(1, 1);
    clr_cnt = 1'b1;
    cycle(1, 0);
    clr_cnt = 1'b0;
    check("clr+match dout_ov", dout_ov, 1);
    check("clr+match cnt_ov", cnt_ov, 1);
    check("clr+match cnt_nov", cnt_nov, 1);
    check("clr+match cnt_c2", cnt_c2, 1);

    // Asynchronous reset while in HIT.
    rst = 1'b0;
    #1;
    check("async rst dout_ov", dout_ov, 0);
    check("async rst dout_nov", dout_nov, 0);
    check("async rst cnt_ov", cnt_ov, 0);
    check("async rst cnt_c2", cnt_c2, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Reset pattern restored: 1001 matches again.
    cycle(1, 0);
    cycle(1, 1); cycle(1, 0); cycle(1, 0); cycle(1, 1);
    check("post-rst match dout", dout_ov, 1);
    check("post-rst cnt_ov", cnt_ov, 1);

    // Plain clear without a match.
    clr_cnt = 1'b1;
    cycle(0, 0);
    clr_cnt = 1'b0;
    check("clr cnt_ov", cnt_ov, 0);
    check("clr cnt_nov", cnt_nov, 0);
    check("clr dout", dout_ov, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Parametrised Moore-style serial sequence detector. It is the successor to the fixed 4-bit "1001" detector. Pattern length, reset pattern and overlap mode are set by parameters, the pattern can be reloaded at run time, and a saturating match counter is added. It sits on a serial bit stream behind a sample-enable qualifier and produces a one-cycle registered match pulse.

Parameters:
N, 4, pattern length in bits; legal range N >= 2.
PATTERN, 4'b1001, reset-time pattern, N bits wide; MSB is the first bit received.
OVERLAP, 1, 1 = overlapping matches allowed; 0 = history discarded after each match.
CNT_W, 8, width of the match counter.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  reset; asynchronous, active-low.
en  input  1  sample enable; din is consumed only on cycles where en=1.
din  input  1  serial data bit.
load  input  1  load pat_in into the pattern register.
pat_in  input  N  new pattern, MSB first.
clr_cnt  input  1  synchronous clear of match_cnt.
dout  output  1  match pulse; Moore output, high only in state HIT.
match_cnt  output  CNT_W  saturating count of matches.

Behaviour:
- Reset (rst=0, asynchronous): takes effect immediately.
  - state=IDLE, hist=0, fill=0, pat=PATTERN, match_cnt=0, dout=0.
  - Reset asserted while in HIT forces dout low without waiting for a clock edge.
- Internal state:
  - hist: N-bit shift register holding the last sampled bits.
  - fill: count of valid history bits, range 0..N, saturating at N.
  - pat: N-bit pattern register.
- FSM states:
  - IDLE: first cycle after reset release. din and en are ignored. Next state is RUN unconditionally. load is still honoured in this state.
  - RUN: dout=0.
  - HIT: dout=1.
- Match event, evaluated in RUN or HIT when en=1 and load=0:
  - Condition: {hist[N-2:0], din} == pat AND fill >= N-1.
  - The fill check stops reset-zero history from producing false matches.
- Sampling, on each en=1 cycle in RUN or HIT:
  - hist <= {hist[N-2:0], din}.
  - fill <= min(fill+1, N).
- On a match event:
  - Next state is HIT.
  - match_cnt increments on the same edge, saturating at 2^CNT_W-1.
  - If OVERLAP=0, fill <= 0 instead of incrementing.
- Otherwise, next state is RUN.
- Latency: dout rises in the cycle after the edge that samples the final pattern bit, and lasts exactly 1 cycle unless the next sample also matches. Back-to-back HIT is possible only when OVERLAP=1 and the pattern allows it, e.g. all-ones.
- en=0 in RUN or HIT:
  - hist, fill and match_cnt hold.
  - Next state is RUN, so dout drops after one cycle.
  - Gaps in en do not break a partial match.
- load=1, any state after reset:
  - pat <= pat_in, fill <= 0, next state RUN.
  - load has priority over en; the din on that cycle is discarded.
  - match_cnt is unaffected.
- clr_cnt=1: match_cnt <= 0. If a match event occurs on the same cycle, match_cnt <= 1.
- Unused state encodings recover to IDLE.

Test Plan:
- N=4, PATTERN=1001. Release reset, drive din=1 during the IDLE cycle, then stream 1,0,0,1 with en=1 -> dout=1 for exactly the one cycle after the 4th sample; match_cnt=1. The IDLE-cycle bit is not counted.
- Stream 1,0,0,1,0,0,1. OVERLAP=1 -> two dout pulses 3 samples apart, match_cnt=2. OVERLAP=0 -> one pulse, match_cnt=1.
- Sample 1,0, hold en=0 for 3 cycles, sample 0,1 -> one dout pulse after the final sample; no dout activity during the gap.
- pat_in=4'b0001, load; right after the load cycle, sample a single 1 -> no match (fill check). Then sample 0,0,0,1 -> match.
- Mid-stream, after sampling 1,0,0, pulse load with pat_in=4'b1110 while en=1 -> that cycle's din is ignored. A following 1 does not match; 1,1,1,0 does match.
- CNT_W=2: 4 matches -> match_cnt stays 3. clr_cnt coincident with a match -> match_cnt=1. Drive rst=0 during HIT -> dout=0 immediately and match_cnt=0.
